// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch alignment path: state encodings,
// halfword/PC widths and the compressed-halfword test.
package fetch_pkg;

  localparam int unsigned PC_W = 32;
  localparam int unsigned HW_W = 16;

  localparam logic [1:0] S_EMPTY  = 2'd0;
  localparam logic [1:0] S_H16    = 2'd1;
  localparam logic [1:0] S_H32    = 2'd2;
  localparam logic [1:0] S_SKIPLO = 2'd3;

  function automatic logic is_rv16(input logic [HW_W-1:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/rv16torv32.sv
// RV32C to RV32I expander. Any reserved or unsupported encoding yields 32'h0,
// which downstream treats as illegal.
module rv16torv32
  import fetch_pkg::*;
(
  input  logic [HW_W-1:0] i_hw,
  output logic [31:0]     o_ins
);

  logic [4:0] w_rd;
  logic [4:0] w_rs2;
  logic [4:0] w_rdp;
  logic [4:0] w_rs2p;
  logic [2:0] w_f3;

  assign w_rd   = i_hw[11:7];
  assign w_rs2  = i_hw[6:2];
  assign w_rdp  = {2'b01, i_hw[9:7]};
  assign w_rs2p = {2'b01, i_hw[4:2]};
  assign w_f3   = i_hw[15:13];

  always_comb begin
    o_ins = '0;
    case (i_hw[1:0])
      2'b00: begin
        case (w_f3)
          3'b000: if ({i_hw[10:7], i_hw[12:11], i_hw[5], i_hw[6]} != 8'd0)
            o_ins = {2'b00, i_hw[10:7], i_hw[12:11], i_hw[5], i_hw[6], 2'b00,
                     5'd2, 3'b000, w_rs2p, 7'b0010011};
          3'b010: o_ins = {5'b0, i_hw[5], i_hw[12:10], i_hw[6], 2'b00,
                           w_rdp, 3'b010, w_rs2p, 7'b0000011};
          3'b110: o_ins = {5'b0, i_hw[5], i_hw[12], w_rs2p, w_rdp, 3'b010,
                           i_hw[11:10], i_hw[6], 2'b00, 7'b0100011};
          default: o_ins = '0;
        endcase
      end
      2'b01: begin
        case (w_f3)
          3'b000: o_ins = {{7{i_hw[12]}}, i_hw[6:2], w_rd, 3'b000, w_rd, 7'b0010011};
          3'b001, 3'b101:
            o_ins = {i_hw[12], i_hw[8], i_hw[10:9], i_hw[6], i_hw[7], i_hw[2],
                     i_hw[11], i_hw[5:3], i_hw[12], {8{i_hw[12]}},
                     (w_f3 == 3'b001) ? 5'd1 : 5'd0, 7'b1101111};
          3'b010: o_ins = {{7{i_hw[12]}}, i_hw[6:2], 5'd0, 3'b000, w_rd, 7'b0010011};
          3'b011: begin
            if ({i_hw[12], i_hw[6:2]} == 6'd0)
              o_ins = '0;
            else if (w_rd == 5'd2)
              o_ins = {{3{i_hw[12]}}, i_hw[4:3], i_hw[5], i_hw[2], i_hw[6], 4'b0000,
                       5'd2, 3'b000, 5'd2, 7'b0010011};
            else
              o_ins = {{15{i_hw[12]}}, i_hw[6:2], w_rd, 7'b0110111};
          end
          3'b100: begin
            case (i_hw[11:10])
              2'b00: if (!i_hw[12])
                o_ins = {7'b0000000, i_hw[6:2], w_rdp, 3'b101, w_rdp, 7'b0010011};
              2'b01: if (!i_hw[12])
                o_ins = {7'b0100000, i_hw[6:2], w_rdp, 3'b101, w_rdp, 7'b0010011};
              2'b10: o_ins = {{7{i_hw[12]}}, i_hw[6:2], w_rdp, 3'b111, w_rdp, 7'b0010011};
              default: if (!i_hw[12]) begin
                case (i_hw[6:5])
                  2'b00:   o_ins = {7'b0100000, w_rs2p, w_rdp, 3'b000, w_rdp, 7'b0110011};
                  2'b01:   o_ins = {7'b0000000, w_rs2p, w_rdp, 3'b100, w_rdp, 7'b0110011};
                  2'b10:   o_ins = {7'b0000000, w_rs2p, w_rdp, 3'b110, w_rdp, 7'b0110011};
                  default: o_ins = {7'b0000000, w_rs2p, w_rdp, 3'b111, w_rdp, 7'b0110011};
                endcase
              end
            endcase
          end
          3'b110, 3'b111:
            o_ins = {i_hw[12], {3{i_hw[12]}}, i_hw[6:5], i_hw[2], 5'd0, w_rdp,
                     {2'b00, w_f3[0]}, i_hw[11:10], i_hw[4:3], i_hw[12], 7'b1100011};
          default: o_ins = '0;
        endcase
      end
      2'b10: begin
        case (w_f3)
          3'b000: if (!i_hw[12])
            o_ins = {7'b0000000, i_hw[6:2], w_rd, 3'b001, w_rd, 7'b0010011};
          3'b010: if (w_rd != 5'd0)
            o_ins = {4'b0000, i_hw[3:2], i_hw[12], i_hw[6:4], 2'b00,
                     5'd2, 3'b010, w_rd, 7'b0000011};
          3'b100: begin
            if (!i_hw[12]) begin
              if (w_rs2 != 5'd0)
                o_ins = {7'b0000000, w_rs2, 5'd0, 3'b000, w_rd, 7'b0110011};
              else if (w_rd != 5'd0)
                o_ins = {12'd0, w_rd, 3'b000, 5'd0, 7'b1100111};
            end else begin
              if (w_rs2 != 5'd0)
                o_ins = {7'b0000000, w_rs2, w_rd, 3'b000, w_rd, 7'b0110011};
              else if (w_rd != 5'd0)
                o_ins = {12'd0, w_rd, 3'b000, 5'd1, 7'b1100111};
              else
                o_ins = 32'h0010_0073;
            end
          end
          3'b110: o_ins = {4'b0000, i_hw[8:7], i_hw[12], w_rs2, 5'd2, 3'b010,
                           i_hw[11:9], 2'b00, 7'b0100011};
          default: o_ins = '0;
        endcase
      end
      default: o_ins = '0;
    endcase
  end

endmodule

// File: rtl/fetch_align_ctrl.sv
// Splits sequential fetch words into 16/32-bit instructions, joins straddling
// 32-bit instructions and expands compressed ones for decode.
module fetch_align_ctrl
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            fw_valid,
  output logic            fw_ready,
  input  logic [31:0]     fw_data,
  input  logic            fw_err,
  output logic            ins_valid,
  input  logic            ins_ready,
  output logic [31:0]     ins_data,
  output logic [PC_W-1:0] ins_pc,
  output logic            ins_is16,
  output logic            ins_illegal,
  output logic            ins_fault
);

  logic [1:0]      r_state;
  logic [PC_W-1:0] r_pc;
  logic [HW_W-1:0] r_hold_hw;
  logic            r_hold_err;
  logic            r_ins_valid;
  logic [31:0]     r_ins_data;
  logic [PC_W-1:0] r_ins_pc;
  logic            r_ins_is16;
  logic            r_ins_illegal;
  logic            r_ins_fault;

  logic [HW_W-1:0] w_fw_lo;
  logic [HW_W-1:0] w_fw_hi;
  logic            w_load;
  logic            w_fw_fire;
  logic [HW_W-1:0] w_exp_in;
  logic [31:0]     w_exp_out;
  logic            w_emit;
  logic [31:0]     w_emit_data;
  logic            w_emit_is16;
  logic            w_emit_fault;
  logic            w_emit_ill;
  logic [1:0]      w_next_state;
  logic            w_hold_we;

  assign w_fw_lo   = fw_data[15:0];
  assign w_fw_hi   = fw_data[31:16];
  assign w_load    = !r_ins_valid || ins_ready;
  assign fw_ready  = !redirect && w_load && (r_state != S_H16);
  assign w_fw_fire = fw_valid && fw_ready;

  rv16torv32 u_exp (
    .i_hw  (w_exp_in),
    .o_ins (w_exp_out)
  );

  // The single expander sees whichever halfword the current state may emit.
  always_comb begin
    case (r_state)
      S_H16:    w_exp_in = r_hold_hw;
      S_SKIPLO: w_exp_in = w_fw_hi;
      default:  w_exp_in = w_fw_lo;
    endcase
  end

  always_comb begin
    w_emit       = 1'b0;
    w_emit_data  = w_exp_out;
    w_emit_is16  = 1'b1;
    w_emit_fault = fw_err;
    w_next_state = r_state;
    w_hold_we    = 1'b0;
    case (r_state)
      S_EMPTY: if (w_fw_fire) begin
        w_emit = 1'b1;
        if (is_rv16(w_fw_lo)) begin
          w_hold_we    = 1'b1;
          w_next_state = is_rv16(w_fw_hi) ? S_H16 : S_H32;
        end else begin
          w_emit_data = fw_data;
          w_emit_is16 = 1'b0;
        end
      end
      S_H16: begin
        w_emit       = 1'b1;
        w_emit_fault = r_hold_err;
        w_next_state = S_EMPTY;
      end
      S_H32: if (w_fw_fire) begin
        w_emit       = 1'b1;
        w_emit_data  = {w_fw_lo, r_hold_hw};
        w_emit_is16  = 1'b0;
        w_emit_fault = r_hold_err | fw_err;
        w_hold_we    = 1'b1;
        w_next_state = is_rv16(w_fw_hi) ? S_H16 : S_H32;
      end
      default: if (w_fw_fire) begin
        if (is_rv16(w_fw_hi)) begin
          w_emit       = 1'b1;
          w_next_state = S_EMPTY;
        end else begin
          w_hold_we    = 1'b1;
          w_next_state = S_H32;
        end
      end
    endcase
  end

  assign w_emit_ill = w_emit_is16 && (w_exp_out == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= RESET_PC[1] ? S_SKIPLO : S_EMPTY;
      r_pc          <= {RESET_PC[PC_W-1:1], 1'b0};
      r_hold_hw     <= '0;
      r_hold_err    <= 1'b0;
      r_ins_valid   <= 1'b0;
      r_ins_data    <= '0;
      r_ins_pc      <= '0;
      r_ins_is16    <= 1'b0;
      r_ins_illegal <= 1'b0;
      r_ins_fault   <= 1'b0;
    end else if (redirect) begin
      r_ins_valid <= 1'b0;
      r_pc        <= {redirect_pc[PC_W-1:1], 1'b0};
      r_hold_hw   <= '0;
      r_hold_err  <= 1'b0;
      r_state     <= redirect_pc[1] ? S_SKIPLO : S_EMPTY;
    end else if (w_load) begin
      r_ins_valid <= w_emit;
      if (w_emit) begin
        r_ins_data    <= w_emit_data;
        r_ins_pc      <= r_pc;
        r_ins_is16    <= w_emit_is16;
        r_ins_illegal <= w_emit_ill;
        r_ins_fault   <= w_emit_fault;
        r_pc          <= r_pc + (w_emit_is16 ? 32'd2 : 32'd4);
      end
      r_state <= w_next_state;
      if (w_hold_we) begin
        r_hold_hw  <= w_fw_hi;
        r_hold_err <= fw_err;
      end
    end
  end

  assign ins_valid   = r_ins_valid;
  assign ins_data    = r_ins_data;
  assign ins_pc      = r_ins_pc;
  assign ins_is16    = r_ins_is16;
  assign ins_illegal = r_ins_illegal;
  assign ins_fault   = r_ins_fault;

endmodule
